// File: rtl/axi3_pkg.sv
// axi3_pkg: shared widths, line type and read FSM state encoding for the
// axi3 behavioural line memory.
package axi3_pkg;
  localparam int LINE_W   = 128;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 4;   // byte offset within a 16-byte line

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic {R_IDLE, R_WAIT} rd_st_e;
endpackage

// File: rtl/axi3_if.sv
// axi3_if: request/return bus between the data cache (master) and the
// line memory (slave).
//   write : wr_req, wr_addr, wr_data -> wr_rdy
//   read  : rd_req, rd_addr          -> rd_rdy, ret_valid, ret_data
//   preload patterns : data_from_cpu0 (even lines), data_from_cpu1 (odd lines)
interface axi3_if;
  import axi3_pkg::*;

  logic  wr_req;
  addr_t wr_addr;
  line_t wr_data;
  logic  wr_rdy;
  logic  rd_req;
  addr_t rd_addr;
  logic  rd_rdy;
  logic  ret_valid;
  line_t ret_data;
  line_t data_from_cpu0;
  line_t data_from_cpu1;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, data_from_cpu0, data_from_cpu1,
    input  wr_rdy, rd_rdy, ret_valid, ret_data
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, data_from_cpu0, data_from_cpu1,
    output wr_rdy, rd_rdy, ret_valid, ret_data
  );
endinterface

// File: rtl/axi3_line_mem.sv
// axi3_line_mem: LINES x 128-bit register array.
//   clk, rst      : clock, synchronous preload (even <- pre0, odd <- pre1)
//   wr_en/idx/data: single write port, written on the clock edge
//   rd_idx/rd_data: combinational read with write-first bypass
module axi3_line_mem
  import axi3_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  line_t            pre0,
  input  line_t            pre1,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  line_t            wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output line_t            rd_data
);
  line_t mem [LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) mem[i] <= i[0] ? pre1 : pre0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // A read sampled on the same edge as a write to that line sees the new data.
  always_comb begin
    rd_data = mem[rd_idx];
    if (wr_en && (wr_idx == rd_idx)) rd_data = wr_data;
  end
endmodule

// File: rtl/axi3.sv
// axi3: behavioural line memory for data cache refills / write-backs.
//   clk, rst : clock, synchronous active-high reset (reloads all lines)
//   bus      : axi3_if.slave (read request/return, write request, preload)
// Reads return a latched line READ_LAT cycles after acceptance as a
// one-cycle ret_valid pulse. Define AXI3_WR_BUSY_EN to make wr_rdy drop for
// WRITE_LAT cycles after each accepted write; otherwise wr_rdy stays high.
module axi3
  import axi3_pkg::*;
#(
  parameter int LINES     = 16,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 2
) (
  input logic clk,
  input logic rst,
  axi3_if.slave bus
);
  localparam int IDX_W = $clog2(LINES);

  rd_st_e              state, state_nxt;
  logic                up;           // low during reset, high from first post-reset edge
  logic [READ_LAT:0]   vld_pipe;     // bit k set k edges after acceptance
  line_t               lat_line;
  line_t               rd_line;
  logic                rd_fire, wr_fire;
  logic [IDX_W-1:0]    rd_idx, wr_idx;

  assign rd_idx  = bus.rd_addr[OFFSET_W +: IDX_W];
  assign wr_idx  = bus.wr_addr[OFFSET_W +: IDX_W];
  assign rd_fire = bus.rd_req & bus.rd_rdy;
  assign wr_fire = bus.wr_req & bus.wr_rdy;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.rd_addr[ADDR_W-1:OFFSET_W+IDX_W], bus.rd_addr[OFFSET_W-1:0],
                              bus.wr_addr[ADDR_W-1:OFFSET_W+IDX_W], bus.wr_addr[OFFSET_W-1:0]};

  axi3_line_mem #(.LINES(LINES), .IDX_W(IDX_W)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .pre0    (bus.data_from_cpu0),
    .pre1    (bus.data_from_cpu1),
    .wr_en   (wr_fire),
    .wr_idx  (wr_idx),
    .wr_data (bus.wr_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_line)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      R_IDLE: if (rd_fire) state_nxt = R_WAIT;
      R_WAIT: if (vld_pipe[READ_LAT-1]) state_nxt = R_IDLE;
      default: state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= R_IDLE;
      up       <= 1'b0;
      vld_pipe <= '0;
      lat_line <= '0;
      bus.ret_data <= '0;
    end else begin
      state    <= state_nxt;
      up       <= 1'b1;
      vld_pipe <= {vld_pipe[READ_LAT-1:0], rd_fire};
      // Latch at acceptance so later writes cannot disturb an in-flight read.
      if (rd_fire) lat_line <= rd_line;
      if (vld_pipe[READ_LAT-1]) bus.ret_data <= lat_line;
    end
  end

  assign bus.ret_valid = vld_pipe[READ_LAT];
  assign bus.rd_rdy    = up & (state == R_IDLE);

`ifdef AXI3_WR_BUSY_EN
  localparam int WC_W = $clog2(WRITE_LAT + 1);
  logic [WC_W-1:0] wr_cnt;

  always_ff @(posedge clk) begin
    if (rst)             wr_cnt <= '0;
    else if (wr_fire)    wr_cnt <= WC_W'(WRITE_LAT);
    else if (wr_cnt != 0) wr_cnt <= wr_cnt - 1'b1;
  end

  assign bus.wr_rdy = up & (wr_cnt == '0);
`else
  assign bus.wr_rdy = up;
`endif
endmodule

// File: tb/tb_axi3.sv
module tb_axi3;
  import axi3_pkg::*;

  localparam int RL = 2;
  localparam line_t PAT0 = {8{16'hAAAA}};
  localparam line_t PAT1 = {8{16'h5555}};
  localparam line_t V3   = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam line_t VDB  = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi3_if bus();
  axi3 #(.LINES(16), .READ_LAT(RL), .WRITE_LAT(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_run  = 0;
  int n_fail = 0;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_rd_rdy(input string name);
    for (int c = 0; c < 20 && !bus.rd_rdy; c++) tick();
    n_run++;
    if (bus.rd_rdy !== 1'b1) begin
      n_fail++; $display("FAIL %s rd_rdy timeout: got %b want 1", name, bus.rd_rdy);
    end
  endtask

  task automatic wait_wr_rdy(input string name);
    for (int c = 0; c < 20 && !bus.wr_rdy; c++) tick();
    n_run++;
    if (bus.wr_rdy !== 1'b1) begin
      n_fail++; $display("FAIL %s wr_rdy timeout: got %b want 1", name, bus.wr_rdy);
    end
  endtask

  // Called right after the acceptance edge; checks latency and returned line.
  task automatic wait_ret(input line_t exp, input string name);
    int k = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (bus.ret_valid) begin k = c; break; end
    end
    n_run++;
    if (k != RL) begin
      n_fail++; $display("FAIL %s latency: got %0d want %0d", name, k, RL);
    end
    n_run++;
    if (bus.ret_data !== exp) begin
      n_fail++; $display("FAIL %s data: got %h want %h", name, bus.ret_data, exp);
    end
  endtask

  task automatic do_read(input addr_t a, input line_t exp, input string name);
    wait_rd_rdy(name);
    bus.rd_req = 1'b1; bus.rd_addr = a;
    tick();
    bus.rd_req = 1'b0;
    wait_ret(exp, name);
  endtask

  task automatic do_write(input addr_t a, input line_t d, input string name);
    wait_wr_rdy(name);
    bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    tick();
    bus.wr_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    bus.wr_addr = '0; bus.rd_addr = '0; bus.wr_data = '0;
    bus.data_from_cpu0 = PAT0; bus.data_from_cpu1 = PAT1;
    tick(); tick();
    n_run++;
    if ({bus.rd_rdy, bus.wr_rdy, bus.ret_valid} !== 3'b000 || bus.ret_data !== '0) begin
      n_fail++; $display("FAIL reset_state: got rd=%b wr=%b v=%b d=%h want 0 0 0 0",
                         bus.rd_rdy, bus.wr_rdy, bus.ret_valid, bus.ret_data);
    end
    rst = 1'b0;
    tick();
    n_run++;
    if ({bus.rd_rdy, bus.wr_rdy} !== 2'b11) begin
      n_fail++; $display("FAIL post_reset_rdy: got rd=%b wr=%b want 1 1", bus.rd_rdy, bus.wr_rdy);
    end
  endtask

  task automatic test_preload;
    do_read(32'h0000_0010, PAT1, "preload_odd");
    do_read(32'h0000_0020, PAT0, "preload_even");
  endtask

  task automatic test_write_offset;
    do_write(32'h0000_0030, V3, "wr_line3");
    do_read(32'h0000_003C, V3, "rd_offset");
  endtask

  task automatic test_write_first;
    wait_rd_rdy("wfirst");
    wait_wr_rdy("wfirst");
    bus.wr_req = 1'b1; bus.wr_addr = 32'h40; bus.wr_data = VDB;
    bus.rd_req = 1'b1; bus.rd_addr = 32'h40;
    tick();
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    wait_ret(VDB, "write_first");
  endtask

  task automatic test_back_to_back;
    wait_rd_rdy("b2b");
    bus.rd_req = 1'b1; bus.rd_addr = 32'h20;
    tick();  // first acceptance, cycle 0
    for (int c = 1; c <= 8; c++) begin
      logic ev;
      tick();
      ev = (c % 3 == 2);
      n_run++;
      if (bus.ret_valid !== ev || bus.rd_rdy !== ev) begin
        n_fail++; $display("FAIL b2b_c%0d: got v=%b rdy=%b want v=%b rdy=%b",
                           c, bus.ret_valid, bus.rd_rdy, ev, ev);
      end
      if (ev) begin
        n_run++;
        if (bus.ret_data !== PAT0) begin
          n_fail++; $display("FAIL b2b_data_c%0d: got %h want %h", c, bus.ret_data, PAT0);
        end
      end
    end
    bus.rd_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_read;
    logic seen = 1'b0;
    wait_rd_rdy("rst_mid");
    bus.rd_req = 1'b1; bus.rd_addr = 32'h30;
    tick();  // accepted
    bus.rd_req = 1'b0;
    rst = 1'b1;
    tick();
    n_run++;
    if (bus.ret_valid !== 1'b0 || bus.ret_data !== '0 || bus.rd_rdy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got v=%b d=%h rdy=%b want 0 0 0",
                         bus.ret_valid, bus.ret_data, bus.rd_rdy);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.ret_valid) seen = 1'b1;
    end
    n_run++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_no_ret: got %b want 0", seen);
    end
    do_read(32'h30, PAT1, "reload_line3");
    do_read(32'h40, PAT0, "reload_line4");
  endtask

  task automatic test_writes;
`ifdef AXI3_WR_BUSY_EN
    wait_wr_rdy("busy");
    bus.wr_req = 1'b1; bus.wr_addr = 32'h60; bus.wr_data = V3;
    tick();  // accepted
    n_run++;
    if (bus.wr_rdy !== 1'b0) begin
      n_fail++; $display("FAIL busy_c0: got %b want 0", bus.wr_rdy);
    end
    bus.wr_addr = 32'h70; bus.wr_data = VDB;
    tick();
    n_run++;
    if (bus.wr_rdy !== 1'b0) begin
      n_fail++; $display("FAIL busy_c1: got %b want 0", bus.wr_rdy);
    end
    bus.wr_req = 1'b0;
    tick();
    n_run++;
    if (bus.wr_rdy !== 1'b1) begin
      n_fail++; $display("FAIL busy_c2: got %b want 1", bus.wr_rdy);
    end
    do_read(32'h60, V3, "busy_stored");
    do_read(32'h70, PAT1, "busy_ignored");
`else
    wait_wr_rdy("stream");
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      w = 32'hC0DE_0000 + 32'(i);
      bus.wr_req = 1'b1; bus.wr_addr = 32'(i) << 4; bus.wr_data = {4{w}};
      tick();
      n_run++;
      if (bus.wr_rdy !== 1'b1) begin
        n_fail++; $display("FAIL stream_rdy_%0d: got %b want 1", i, bus.wr_rdy);
      end
    end
    bus.wr_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      w = 32'hC0DE_0000 + 32'(i);
      do_read(32'(i) << 4, {4{w}}, $sformatf("stream_line%0d", i));
    end
`endif
  endtask

  initial begin
    test_reset();
    test_preload();
    test_write_offset();
    test_write_first();
    test_back_to_back();
    test_reset_mid_read();
    test_writes();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/axi3.md
# axi3

Behavioural AXI-style line memory serving 128-bit cache-line refills and write-backs for the data cache in the CPU3 test system. It holds a small array of 128-bit lines preloaded at reset from two pattern buses. It accepts one read and one write request under ready/request handshakes. Reads return a full line after a fixed latency with a one-cycle valid pulse.

## Interface
Parameters:
- LINES, 16: number of 128-bit lines (power of two); index = addr[4 +: $clog2(LINES)], upper bits and addr[3:0] ignored
- READ_LAT, 2: cycles from read acceptance to ret_valid (≥1)
- WRITE_LAT, 2: write busy cycles (used only with AXI3_WR_BUSY_EN, ≥1)

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- wr_req  in  1  write-back request
- wr_data  in  128  line to write
- wr_addr  in  32  write byte address
- wr_rdy  out  1  write channel can accept
- rd_req  in  1  refill request
- rd_addr  in  32  read byte address
- rd_rdy  out  1  read channel can accept
- ret_valid  out  1  one-cycle pulse, ret_data valid
- ret_data  out  128  returned line
- data_from_cpu0  in  128  preload pattern, even lines
- data_from_cpu1  in  128  preload pattern, odd lines

## Operation
- Reset: every line with even index <= data_from_cpu0, odd index <= data_from_cpu1 (sampled each reset cycle). ret_valid=0, ret_data=0, rd_rdy=0, wr_rdy=0. In-flight read aborted; no ret_valid for it.
- Read FSM states R_IDLE, R_WAIT.
  - R_IDLE: rd_rdy=1. rd_req&rd_rdy at edge E0 accepts the request, latches the line and enters R_WAIT.
  - Latched line: mem[idx], or wr_data if a write to the same index is accepted on E0 (write-first).
  - R_WAIT: rd_rdy=0. rd_req is ignored.
- Write: wr_req&wr_rdy at edge E0 writes wr_data to mem[idx] at E0. Writes accepted while a read is waiting do not alter that read's latched data.
- Read and write are independent; both may be accepted on the same edge.
- ret_data holds its last value between pulses.

## Timing
- After rst deasserts: rd_rdy=1 and wr_rdy=1 from the first post-reset edge.
- Read accepted at E0:
  - rd_rdy=0 from E0 through E0+READ_LAT-1.
  - At edge E0+READ_LAT: ret_valid=1 for exactly one cycle, ret_data=line, rd_rdy=1, FSM returns to R_IDLE.
  - Next read can be accepted at E0+READ_LAT+1. Back-to-back throughput is one read per READ_LAT+1 cycles.
- Write: see Configuration.
- rst asserted mid-read: at the next edge the FSM goes to R_IDLE with outputs at reset values and memory reloaded.

## Configuration
- AXI3_WR_BUSY_EN defined:
  - A write accepted at E0 drives wr_rdy=0 from E0 through E0+WRITE_LAT-1; wr_rdy returns to 1 at E0+WRITE_LAT.
  - Memory is still updated at E0.
- Not defined: wr_rdy stays 1 after reset, so one write can be accepted every cycle.

## Structure
- Package axi3_pkg:
  - LINE_W=128, ADDR_W=32, OFFSET_W=4
  - read FSM enum {R_IDLE, R_WAIT}
- Sub-module axi3_line_mem: LINES×128 register array with synchronous preload on rst, one write port, one combinational read port and write-first bypass.

## Test plan
- Preload: cpu0=128'hAAAA…A, cpu1=128'h5555…5.
  - rd_addr=32'h0000_0010 -> ret_valid exactly 2 cycles after acceptance, ret_data=5555…5.
  - rd_addr=32'h0000_0020 -> ret_data=AAAA…A.
- Write 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677 to 32'h0000_0030, then read 32'h0000_003C -> same value (offset ignored).
- Simultaneous write of 128'hDEAD…BEEF and read of the same line 32'h40 on one edge -> ret_data=DEAD…BEEF.
- Hold rd_req high continuously:
  - rd_rdy low for 2 cycles after each acceptance.
  - One ret_valid pulse per 3 cycles.
  - No duplicate accept during R_WAIT.
- Assert rst one cycle after accepting a read -> no ret_valid; ret_data=0; a written line is reloaded to its preload pattern.
- With AXI3_WR_BUSY_EN: a write at E0 drives wr_rdy=0 for 2 cycles and a wr_req during that window is ignored. Without the macro: 4 consecutive writes to lines 0–3 are all stored.
